// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared constants and types for the instruction fetch stage.
//   NOP_INSTR        : word presented to decode when no valid entry exists
//                      (decodes as SPECIAL/SLL, shamt 0, rd 0).
//   RESET_PC_DEFAULT : default PC loaded on reset.
//   fetch_entry_t    : one buffered {instruction, PC} pair.
//   align_word()     : clears the byte-offset bits of an address.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8002_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
// Instruction-memory read bus between the fetch stage (master) and memory
// (slave).
//   w_imem_req      : request valid (master -> slave)
//   w_imem_addr_32  : word-aligned read address (master -> slave)
//   w_imem_ready    : memory accepts the request this cycle (slave -> master)
//   w_imem_rvalid   : read data valid (slave -> master)
//   w_imem_rdata_32 : read data (slave -> master)
//
// Handshake: a request is issued on a clock edge where w_imem_req and
// w_imem_ready are both high. While w_imem_req is high and not accepted the
// address is held, unless the fetch stage is redirected. Responses have no
// backpressure: each w_imem_rvalid pulse delivers one word, in issue order,
// at least one cycle after the request was accepted.
interface fetch_unit_if;

    logic        w_imem_req;
    logic [31:0] w_imem_addr_32;
    logic        w_imem_ready;
    logic        w_imem_rvalid;
    logic [31:0] w_imem_rdata_32;

    modport master (
        output w_imem_req,
        output w_imem_addr_32,
        input  w_imem_ready,
        input  w_imem_rvalid,
        input  w_imem_rdata_32
    );

    modport slave (
        input  w_imem_req,
        input  w_imem_addr_32,
        output w_imem_ready,
        output w_imem_rvalid,
        output w_imem_rdata_32
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo
// Small synchronous FIFO holding fetched {instr, pc} entries.
//   clock, reset : clock, synchronous active-high reset
//   flush        : empties the FIFO; wins over push and pop
//   push/push_data : write one entry
//   pop          : drop the head entry (ignored when empty)
//   head_data    : current head entry (combinational from storage)
//   empty, count : occupancy
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_W);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing reads it while the FIFO is empty.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    a_no_overflow : assert property (@(posedge clock) disable iff (reset)
        !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage: owns the PC, issues instruction-memory reads,
// buffers returned words in order and presents {instruction, PC} to decode.
//   clock, reset      : clock, synchronous active-high reset
//   w_stall           : decode cannot take the head entry this cycle
//   w_redirect        : taken branch/jump; flush and restart at w_redirect_pc_32
//   w_redirect_pc_32  : redirect target (bits [1:0] forced to zero)
//   imem              : instruction-memory read bus (master side)
//   w_instr_out_32    : head instruction, NOP_INSTR when nothing is valid
//   w_pc_out_32       : PC of the head instruction, zero when nothing is valid
//   w_valid           : head entry valid
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                w_stall,
    input  logic                w_redirect,
    input  logic [31:0]         w_redirect_pc_32,
    fetch_unit_if.master        imem,
    output logic [31:0]         w_instr_out_32,
    output logic [31:0]         w_pc_out_32,
    output logic                w_valid
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    // Addresses of issued reads, consumed as responses are accepted.
    logic [31:0]   tag_mem_q [BUF_DEPTH];
    logic [31:0]   tag_mem_d [BUF_DEPTH];
    logic [AW-1:0] tag_wr_q, tag_wr_d;
    logic [AW-1:0] tag_rd_q, tag_rd_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic [63:0]   fifo_head;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          pop;
    logic          issue;
    logic          accept;
    logic          req;
    logic [CW:0]   credit_used;

    assign head    = fifo_head;
    assign w_valid = !fifo_empty;
    assign pop     = w_valid && !w_stall;

    // Credit counts a head leaving this cycle as already freed, which keeps
    // one read in flight every cycle with a one-cycle memory and two entries.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q}
                       + {1'b0, drop_q} - {{CW{1'b0}}, pop};

    assign req    = !reset && !w_redirect && (credit_used < DEPTH_W);
    assign issue  = req && imem.w_imem_ready;
    assign accept = imem.w_imem_rvalid && (drop_q == '0) && !w_redirect;

    assign imem.w_imem_req     = req;
    assign imem.w_imem_addr_32 = fetch_pc_q;

    assign push_entry.instr = imem.w_imem_rdata_32;
    assign push_entry.pc    = tag_mem_q[tag_rd_q];

    assign w_instr_out_32 = w_valid ? head.instr : NOP_INSTR;
    assign w_pc_out_32    = w_valid ? head.pc    : 32'h0;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        tag_mem_d     = tag_mem_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        if (w_redirect) begin
            // Every read still in flight becomes wrong-path; a response
            // arriving this very cycle retires one of them.
            fetch_pc_d    = align_word(w_redirect_pc_32);
            outstanding_d = '0;
            tag_wr_d      = '0;
            tag_rd_d      = '0;
            drop_d        = drop_q + outstanding_q - {{AW{1'b0}}, imem.w_imem_rvalid};
        end else begin
            if (issue) begin
                fetch_pc_d          = fetch_pc_q + 32'd4;
                tag_mem_d[tag_wr_q] = fetch_pc_q;
                tag_wr_d            = tag_wr_q + 1'b1;
            end
            if (accept) begin
                tag_rd_d = tag_rd_q + 1'b1;
            end
            // Old-path words return first, so they are the ones discarded.
            if (imem.w_imem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
            case ({issue, accept})
                2'b10:   outstanding_d = outstanding_q + 1'b1;
                2'b01:   outstanding_d = outstanding_q - 1'b1;
                default: outstanding_d = outstanding_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
        end
    end

    always_ff @(posedge clock) begin
        tag_mem_q <= tag_mem_d;
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (w_redirect),
        .push      (accept),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    a_rvalid_expected : assert property (@(posedge clock) disable iff (reset)
        imem.w_imem_rvalid |-> ((outstanding_q != '0) || (drop_q != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit with a behavioural in-order memory that
// returns the read address as data after a programmable latency.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        w_stall = 1'b0;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc_32 = 32'h0;
    logic [31:0] w_instr_out_32;
    logic [31:0] w_pc_out_32;
    logic        w_valid;

    int n_total = 0;
    int n_bad   = 0;
    int mem_lat = 1;
    int edge_n  = 0;
    int first_cyc;

    always #5 clock = ~clock;

    fetch_unit_if imem ();

    fetch_unit #(
        .RESET_PC  (32'h8002_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .w_stall          (w_stall),
        .w_redirect       (w_redirect),
        .w_redirect_pc_32 (w_redirect_pc_32),
        .imem             (imem),
        .w_instr_out_32   (w_instr_out_32),
        .w_pc_out_32      (w_pc_out_32),
        .w_valid          (w_valid)
    );

    // ---------------- memory model ----------------
    // A read accepted at edge n is presented during the cycle ending at edge
    // n + mem_lat, so mem_lat = 1 returns data the cycle after the request.
    logic [31:0] mq_addr [$];
    int          mq_due  [$];

    always @(posedge clock) begin
        edge_n <= edge_n + 1;
        if (reset) begin
            mq_addr.delete();
            mq_due.delete();
            imem.w_imem_rvalid   <= 1'b0;
            imem.w_imem_rdata_32 <= 32'h0;
        end else begin
            if (imem.w_imem_req && imem.w_imem_ready) begin
                mq_addr.push_back(imem.w_imem_addr_32);
                mq_due.push_back(edge_n + mem_lat);
            end
            if (mq_due.size() > 0 && mq_due[0] <= edge_n + 1) begin
                imem.w_imem_rvalid   <= 1'b1;
                imem.w_imem_rdata_32 <= mq_addr[0];
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end else begin
                imem.w_imem_rvalid   <= 1'b0;
                imem.w_imem_rdata_32 <= 32'h0;
            end
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Decoder view of a nop: SPECIAL/SLL, rd 0, shamt 0.
    function automatic logic is_nop(input logic [31:0] i);
        return (i[31:26] == 6'd0) && (i[15:11] == 5'd0) && (i[10:6] == 5'd0) && (i[5:0] == 6'd0);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycle_in(input logic stall, input logic redir, input logic [31:0] rpc, input logic rdy);
        @(posedge clock);
        #1;
        w_stall          = stall;
        w_redirect       = redir;
        w_redirect_pc_32 = rpc;
        imem.w_imem_ready = rdy;
        #1;
    endtask

    // Leaves the bench in cycle 0: first cycle with reset low.
    task automatic do_reset(input int lat);
        mem_lat           = lat;
        reset             = 1'b1;
        w_stall           = 1'b0;
        w_redirect        = 1'b0;
        w_redirect_pc_32  = 32'h0;
        imem.w_imem_ready = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        imem.w_imem_ready = 1'b1;

        // Reset state
        @(posedge clock);
        #2;
        check("rst_valid", w_valid, 0);
        check("rst_req", imem.w_imem_req, 0);
        check("rst_instr", w_instr_out_32, 32'h0);
        check("rst_pc", w_pc_out_32, 32'h0);

        // Streaming with a one-cycle memory, then a 5-cycle stall
        do_reset(1);
        check("t1_c0_req", imem.w_imem_req, 1);
        check("t1_c0_addr", imem.w_imem_addr_32, 32'h8002_0000);
        check("t1_c0_valid", w_valid, 0);
        cycle_in(0, 0, 0, 1);
        check("t1_c1_addr", imem.w_imem_addr_32, 32'h8002_0004);
        check("t1_c1_valid", w_valid, 0);
        cycle_in(0, 0, 0, 1);
        check("t1_c2_valid", w_valid, 1);
        check("t1_c2_pc", w_pc_out_32, 32'h8002_0000);
        check("t1_c2_instr", w_instr_out_32, 32'h8002_0000);
        check("t1_c2_addr", imem.w_imem_addr_32, 32'h8002_0008);
        cycle_in(0, 0, 0, 1);
        check("t1_c3_pc", w_pc_out_32, 32'h8002_0004);
        check("t1_c3_addr", imem.w_imem_addr_32, 32'h8002_000C);
        for (int k = 0; k < 5; k++) begin
            cycle_in(1, 0, 0, 1);
            check("t1_stall_valid", w_valid, 1);
            check("t1_stall_pc", w_pc_out_32, 32'h8002_0008);
            check("t1_stall_instr", w_instr_out_32, 32'h8002_0008);
            check("t1_stall_req", imem.w_imem_req, 0);
        end
        cycle_in(0, 0, 0, 1);
        check("t1_rel0_pc", w_pc_out_32, 32'h8002_0008);
        check("t1_rel0_req", imem.w_imem_req, 1);
        check("t1_rel0_addr", imem.w_imem_addr_32, 32'h8002_0010);
        cycle_in(0, 0, 0, 1);
        check("t1_rel1_pc", w_pc_out_32, 32'h8002_000C);
        cycle_in(0, 0, 0, 1);
        check("t1_rel2_pc", w_pc_out_32, 32'h8002_0010);

        // Redirect with two reads outstanding on a three-cycle memory
        do_reset(3);
        check("t2_c0_addr", imem.w_imem_addr_32, 32'h8002_0000);
        cycle_in(0, 0, 0, 1);
        check("t2_c1_addr", imem.w_imem_addr_32, 32'h8002_0004);
        check("t2_c1_req", imem.w_imem_req, 1);
        cycle_in(0, 1, 32'h8002_0101, 1);
        check("t2_redir_req", imem.w_imem_req, 0);
        cycle_in(0, 0, 0, 1);
        check("t2_c3_addr", imem.w_imem_addr_32, 32'h8002_0100);
        check("t2_c3_req", imem.w_imem_req, 0);
        check("t2_c3_valid", w_valid, 0);
        first_cyc = -1;
        for (int k = 4; k < 16 && first_cyc < 0; k++) begin
            cycle_in(0, 0, 0, 1);
            if (w_valid) first_cyc = k;
        end
        check("t2_first_cyc", first_cyc, 8);
        check("t2_first_pc", w_pc_out_32, 32'h8002_0100);
        check("t2_first_instr", w_instr_out_32, 32'h8002_0100);
        cycle_in(0, 0, 0, 1);
        check("t2_second_pc", w_pc_out_32, 32'h8002_0104);

        // Redirect together with an arriving response and a stall
        do_reset(1);
        cycle_in(0, 0, 0, 1);
        cycle_in(0, 0, 0, 1);
        cycle_in(1, 1, 32'h8003_0000, 1);
        check("t3_redir_pc", w_pc_out_32, 32'h8002_0004);
        check("t3_redir_req", imem.w_imem_req, 0);
        cycle_in(0, 0, 0, 1);
        check("t3_c4_valid", w_valid, 0);
        check("t3_c4_instr", w_instr_out_32, 32'h0);
        check("t3_c4_pcout", w_pc_out_32, 32'h0);
        check("t3_c4_addr", imem.w_imem_addr_32, 32'h8003_0000);
        check("t3_c4_req", imem.w_imem_req, 1);
        cycle_in(0, 0, 0, 1);
        check("t3_c5_valid", w_valid, 0);
        cycle_in(0, 0, 0, 1);
        check("t3_c6_valid", w_valid, 1);
        check("t3_c6_pc", w_pc_out_32, 32'h8003_0000);

        // Memory not ready for four cycles
        do_reset(1);
        imem.w_imem_ready = 1'b0;
        #1;
        check("t4_req", imem.w_imem_req, 1);
        check("t4_addr", imem.w_imem_addr_32, 32'h8002_0000);
        check("t4_valid", w_valid, 0);
        check("t4_instr", w_instr_out_32, 32'h0);
        check("t4_nop", {31'd0, is_nop(w_instr_out_32)}, 1);
        for (int k = 1; k < 4; k++) begin
            cycle_in(0, 0, 0, 0);
            check("t4_req", imem.w_imem_req, 1);
            check("t4_addr", imem.w_imem_addr_32, 32'h8002_0000);
            check("t4_valid", w_valid, 0);
            check("t4_nop", {31'd0, is_nop(w_instr_out_32)}, 1);
        end
        cycle_in(0, 0, 0, 1);
        check("t4_c4_addr", imem.w_imem_addr_32, 32'h8002_0000);
        cycle_in(0, 0, 0, 1);
        check("t4_c5_addr", imem.w_imem_addr_32, 32'h8002_0004);
        check("t4_c5_valid", w_valid, 0);
        cycle_in(0, 0, 0, 1);
        check("t4_c6_pc", w_pc_out_32, 32'h8002_0000);

        // PC wrap at the top of the address space, then reset mid-stream
        do_reset(1);
        w_redirect       = 1'b1;
        w_redirect_pc_32 = 32'hFFFF_FFFB;
        #1;
        check("t5_redir_req", imem.w_imem_req, 0);
        cycle_in(0, 0, 0, 1);
        check("t5_c1_addr", imem.w_imem_addr_32, 32'hFFFF_FFF8);
        check("t5_c1_req", imem.w_imem_req, 1);
        cycle_in(0, 0, 0, 1);
        check("t5_c2_addr", imem.w_imem_addr_32, 32'hFFFF_FFFC);
        cycle_in(0, 0, 0, 1);
        check("t5_c3_addr", imem.w_imem_addr_32, 32'h0000_0000);
        check("t5_c3_pc", w_pc_out_32, 32'hFFFF_FFF8);
        cycle_in(0, 0, 0, 1);
        check("t5_c4_addr", imem.w_imem_addr_32, 32'h0000_0004);
        check("t5_c4_pc", w_pc_out_32, 32'hFFFF_FFFC);
        reset = 1'b1;
        #1;
        check("t5_rst_req", imem.w_imem_req, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("t5_post_valid", w_valid, 0);
        check("t5_post_instr", w_instr_out_32, 32'h0);
        check("t5_post_pc", w_pc_out_32, 32'h0);
        check("t5_post_addr", imem.w_imem_addr_32, 32'h8002_0000);
        check("t5_post_req", imem.w_imem_req, 1);
        cycle_in(0, 0, 0, 1);
        check("t5_post1_valid", w_valid, 0);
        cycle_in(0, 0, 0, 1);
        check("t5_post2_valid", w_valid, 1);
        check("t5_post2_pc", w_pc_out_32, 32'h8002_0000);

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
